round_scoreboard: RTL
=====================

Name: round_scoreboard

Overview:
- Downstream stage of the round controller (`ctrl`) in the reaction-timer game; it consumes one result record per finished round.
- Keeps a circular history of the last DEPTH rounds and saturating round/win counters.
- Tracks each player's best (minimum non-zero) reaction time.
- Computes each player's win-rate percentage with a sequential divider, for display on the scanned seven-segment driver.

Parameters:
- DEPTH, 8, history entries; power of two, 2..16.
- TW, 10, reaction-time width in ms; 0 means no valid press.
- CMAX, 99, saturation value for round and win counters; must fit in 7 bits.

Ports:
- clk  in  1  system clock.
- clear  in  1  reset, synchronous, active-high.
- rnd_vld  in  1  one-cycle pulse: round result valid.
- rnd_t1  in  TW  player-1 reaction time, ms.
- rnd_t2  in  TW  player-2 reaction time, ms.
- rnd_win  in  2  result code: 01 = P1 win, 10 = P2 win, 00 or 11 = draw/double foul.
- rd_sel  in  log2(DEPTH)  history select; 0 = most recent round.
- rd_t1  out  TW  selected entry, P1 time.
- rd_t2  out  TW  selected entry, P2 time.
- rd_win  out  2  selected entry, result code.
- rounds  out  7  rounds played, saturating at CMAX.
- wins1  out  7  P1 wins, saturating at CMAX.
- wins2  out  7  P2 wins, saturating at CMAX.
- best1  out  TW  P1 best time; all-ones means none yet.
- best2  out  TW  P2 best time; all-ones means none yet.
- rate1  out  7  P1 win rate, percent, floor.
- rate2  out  7  P2 win rate, percent, floor.
- busy  out  1  update or division in progress.
- rate_vld  out  1  one-cycle pulse when rate1 and rate2 are fresh.
- ovf  out  1  sticky flag: a record was dropped while busy.

Behaviour:
- Reset (clear high at a clk edge):
  - Counters, rates, history, write pointer, busy, rate_vld and ovf go to 0.
  - best1 and best2 go to all-ones.
  - FSM goes to IDLE.
  - clear mid-division aborts the division; no rate_vld is produced.
- FSM states: IDLE, UPDATE, DIV1, DIV2, DONE.
  - IDLE: rnd_vld captures the record into input registers; next state is UPDATE.
  - UPDATE (1 cycle): writes history[wptr]; wptr increments modulo DEPTH (wraps and overwrites the oldest entry).
    - If rounds < CMAX: rounds += 1, and the winner's count += 1 when rnd_win is 01 or 10.
    - If rounds == CMAX: counters and rates freeze; history and best times still update.
    - best_k = min(best_k, rnd_tk) only when rnd_tk != 0.
  - DIV1: divider start with dividend wins1*100 (14 bits) and divisor rounds. Restoring algorithm, exactly 14 cycles.
  - DIV2: same as DIV1 for wins2.
  - DONE (1 cycle): rate1 and rate2 registered; rate_vld = 1; busy = 0 in this cycle.
- Latency:
  - rnd_vld sampled at edge N.
  - Counters, bests and history visible after edge N+1.
  - rate_vld high in cycle N+30.
  - busy high for cycles N+1..N+29.
- Divisor never 0 in DIV states, because rounds ≥ 1 after UPDATE. Quotient is ≤ 100 and fits in 7 bits.
- rnd_vld while busy, including in DONE: the record is dropped and ovf is set. ovf clears only on clear.
- Readback:
  - Entry index = (wptr − 1 − rd_sel) mod DEPTH.
  - rd_* are registered, 1-cycle latency from rd_sel.
  - Entries never written read 0.
  - A read and a write to the same entry in the same cycle return the old data.

Optional Feature:
- Macro STREAK_TRACK_EN.
- Defined:
  - Adds outputs streak1 and streak2 (7 bits each): longest consecutive-win run per player, saturating at CMAX.
  - Updated in UPDATE; a draw or a loss resets that player's current run.
  - Reset value 0.
  - Counting freezes together with the other counters when rounds == CMAX.
- Undefined: no streak ports or logic. All other behaviour is identical.

Decomposition:
- Shared package game_pkg:
  - rnd_win codes WIN_NONE, WIN_P1, WIN_P2, WIN_BOTH.
  - CMAX.
  - The NO_TIME all-ones constant.
  - FSM state enum.
- One sub-module, seq_div:
  - 14-bit dividend, 7-bit divisor, start/done handshake.
  - Fixed 14-cycle latency; quotient output only.

Test Plan:
- Reset, then rounds (P1 win, 180 ms / 0), (P2 win, 0 / 240), (draw, 300 / 300). Required:
  - rounds = 3, wins1 = 1, wins2 = 1.
  - best1 = 180, best2 = 240.
  - rate1 = rate2 = 33.
  - rate_vld exactly 30 cycles after each rnd_vld.
- 10 rounds with P2 times 100..109. Required:
  - rd_sel = 0 gives 109; rd_sel = 7 gives 102 (wrap).
  - rd_sel = 0 immediately after reset gives 0.
- Second rnd_vld issued 5 cycles after the first. Required: second record dropped, ovf = 1, rounds increments by exactly 1.
- 101 P1 wins. Required:
  - rounds = 99, wins1 = 99, rate1 = 100.
  - The last record still appears at rd_sel = 0.
- clear asserted mid-DIV1. Required: all outputs at reset values next cycle, no rate_vld pulse.
- With STREAK_TRACK_EN defined: sequence P1, P1, P1, P2, P1. Required: streak1 = 3, streak2 = 1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared result codes, FSM states and constants for the reaction-timer scoreboard.
package game_pkg;
  typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10, WIN_BOTH = 2'b11} win_t;
  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_DIV1, S_DIV2, S_DONE} state_t;
  localparam int CMAX = 99;
  localparam int TW_MAX = 16;
  localparam logic [TW_MAX-1:0] NO_TIME = '1;
endpackage

// File: rtl/round_scoreboard_seq_div.sv
// seq_div: restoring divider, 14-bit dividend by 7-bit divisor, fixed 14 cycles from start to done.
module seq_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [13:0] i_dividend,
  input  logic [6:0]  i_divisor,
  output logic        o_done,
  output logic [6:0]  o_quo
);
  logic [13:0] r_q;
  logic [6:0]  r_rem, r_dv;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic [13:0] w_q, w_qn;
  logic [6:0]  w_r, w_d, w_rn;
  logic [7:0]  w_sh;
  logic        w_ge;
  // the start cycle already performs the first step on the raw inputs
  assign w_q  = i_start ? i_dividend : r_q;
  assign w_r  = i_start ? 7'd0 : r_rem;
  assign w_d  = i_start ? i_divisor : r_dv;
  assign w_sh = {w_r, w_q[13]};
  assign w_ge = w_sh >= {1'b0, w_d};
  assign w_rn = w_ge ? 7'(w_sh - {1'b0, w_d}) : w_sh[6:0];
  assign w_qn = {w_q[12:0], w_ge};
  assign o_done = r_run && r_cnt == 4'd13;
  assign o_quo  = w_qn[6:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_dv  <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start || r_run) begin
      r_q   <= w_qn;
      r_rem <= w_rn;
      r_dv  <= w_d;
      r_cnt <= i_start ? 4'd1 : r_cnt + 4'd1;
      r_run <= !o_done;
    end
  end
endmodule

// File: rtl/round_scoreboard.sv
// round_scoreboard: round history, saturating counters, best times and win-rate percentages.
// Optional STREAK_TRACK_EN adds longest-win-streak outputs streak1/streak2.
module round_scoreboard import game_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int TW = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          rnd_vld,
  input  logic [TW-1:0] rnd_t1,
  input  logic [TW-1:0] rnd_t2,
  input  logic [1:0]    rnd_win,
  input  logic [AW-1:0] rd_sel,
  output logic [TW-1:0] rd_t1,
  output logic [TW-1:0] rd_t2,
  output logic [1:0]    rd_win,
  output logic [6:0]    rounds,
  output logic [6:0]    wins1,
  output logic [6:0]    wins2,
  output logic [TW-1:0] best1,
  output logic [TW-1:0] best2,
  output logic [6:0]    rate1,
  output logic [6:0]    rate2,
`ifdef STREAK_TRACK_EN
  output logic [6:0]    streak1,
  output logic [6:0]    streak2,
`endif
  output logic          busy,
  output logic          rate_vld,
  output logic          ovf
);
  state_t        r_state;
  logic [TW-1:0] r_t1, r_t2;
  logic [1:0]    r_win;
  logic [AW-1:0] r_wptr;
  logic [TW-1:0] r_mem_t1 [DEPTH];
  logic [TW-1:0] r_mem_t2 [DEPTH];
  logic [1:0]    r_mem_w  [DEPTH];
  logic          r_start;
  logic [6:0]    r_rate1t;
`ifdef STREAK_TRACK_EN
  logic [6:0]    r_cur1, r_cur2;
`endif
  logic [AW-1:0] w_rd_idx;
  logic [13:0]   w_dd;
  logic          w_done, w_fz;
  logic [6:0]    w_quo;
  assign w_rd_idx = r_wptr - AW'(1) - rd_sel;
  assign w_dd = 14'(r_state == S_DIV2 ? wins2 : wins1) * 14'd100;
  assign w_fz = rounds == 7'(CMAX);
  seq_div u_div (
    .clk(clk), .rst(clear), .i_start(r_start), .i_dividend(w_dd),
    .i_divisor(rounds), .o_done(w_done), .o_quo(w_quo)
  );
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_t1     <= '0;
      r_t2     <= '0;
      r_win    <= '0;
      r_wptr   <= '0;
      r_start  <= 1'b0;
      r_rate1t <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_t1[i] <= '0;
        r_mem_t2[i] <= '0;
        r_mem_w[i]  <= '0;
      end
      rd_t1    <= '0;
      rd_t2    <= '0;
      rd_win   <= '0;
      rounds   <= '0;
      wins1    <= '0;
      wins2    <= '0;
      best1    <= NO_TIME[TW-1:0];
      best2    <= NO_TIME[TW-1:0];
      rate1    <= '0;
      rate2    <= '0;
`ifdef STREAK_TRACK_EN
      r_cur1   <= '0;
      r_cur2   <= '0;
      streak1  <= '0;
      streak2  <= '0;
`endif
      busy     <= 1'b0;
      rate_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      rate_vld <= 1'b0;
      r_start  <= 1'b0;
      rd_t1    <= r_mem_t1[w_rd_idx];
      rd_t2    <= r_mem_t2[w_rd_idx];
      rd_win   <= r_mem_w[w_rd_idx];
      if (rnd_vld && r_state != S_IDLE) ovf <= 1'b1;
      case (r_state)
        S_IDLE: if (rnd_vld) begin
          r_t1    <= rnd_t1;
          r_t2    <= rnd_t2;
          r_win   <= rnd_win;
          busy    <= 1'b1;
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_mem_t1[r_wptr] <= r_t1;
          r_mem_t2[r_wptr] <= r_t2;
          r_mem_w[r_wptr]  <= r_win;
          r_wptr <= r_wptr + AW'(1);
          if (r_t1 != '0 && r_t1 < best1) best1 <= r_t1;
          if (r_t2 != '0 && r_t2 < best2) best2 <= r_t2;
          if (!w_fz) begin
            rounds <= rounds + 7'd1;
            if (r_win == WIN_P1) wins1 <= wins1 + 7'd1;
            if (r_win == WIN_P2) wins2 <= wins2 + 7'd1;
`ifdef STREAK_TRACK_EN
            r_cur1 <= r_win == WIN_P1 ? r_cur1 + 7'd1 : 7'd0;
            r_cur2 <= r_win == WIN_P2 ? r_cur2 + 7'd1 : 7'd0;
            if (r_win == WIN_P1 && r_cur1 + 7'd1 > streak1) streak1 <= r_cur1 + 7'd1;
            if (r_win == WIN_P2 && r_cur2 + 7'd1 > streak2) streak2 <= r_cur2 + 7'd1;
`endif
          end
          r_start <= 1'b1;
          r_state <= S_DIV1;
        end
        S_DIV1: if (w_done) begin
          r_rate1t <= w_quo;
          r_start  <= 1'b1;
          r_state  <= S_DIV2;
        end
        S_DIV2: if (w_done) begin
          rate1    <= r_rate1t;
          rate2    <= w_quo;
          rate_vld <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
